trivium_gen: RTL

TRIVIUM_GEN -- requirements
Module: trivium_gen

---
 rtl/trivium_gen.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/trivium_gen.sv
// -----------------------------------------------------------------------------
// trivium_gen -- Trivium keystream generator with a streaming XOR datapath.
//
// Loads an 80-bit key and 80-bit IV, runs the 1152-round warm-up, then XORs
// each accepted s_data word with the next W keystream bits (bit i of a word is
// the i-th generated bit). W rounds are unrolled combinationally per advance.
//
// Optional feature (compile-time macro TRIVIUM_GEN_WORD_LIMIT_EN):
//   counts accepted words since the last load; after MAX_WORDS accepts the
//   block enters EXHAUSTED (s_ready=0, err=1) until the next load or rst.
//   Without the macro there is no counter and err is tied low.
//
// Parameters:
//   W          keystream/data bits per cycle (1, 2, 4, 8, 16, 32, 64)
//   MAX_WORDS  keystream word limit (only with TRIVIUM_GEN_WORD_LIMIT_EN)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   key_in   80-bit key, bit k -> state bit s(k+1)
//   iv_in    80-bit IV,  bit k -> state bit s(k+94)
//   load     one-cycle pulse: sample key/iv and (re)start initialisation
//   s_data   input word, s_valid / s_ready handshake
//   m_data   s_data XOR keystream, m_valid / m_ready handshake
//   busy     high during initialisation
//   err      keystream word limit reached
//   status   IDLE=0, INIT=1, RUN=2, EXHAUSTED=3
// -----------------------------------------------------------------------------
module trivium_gen #(
  parameter int W         = 8,
  parameter int MAX_WORDS = 2**20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [79:0]   key_in,
  input  logic [79:0]   iv_in,
  input  logic          load,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          err,
  output logic [1:0]    status
);

  localparam int INIT_CYC = 1152 / W;
  localparam int ICW      = $clog2(INIT_CYC + 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)
      || MAX_WORDS < 1) begin : g_bad_param
    $error("trivium_gen: illegal W or MAX_WORDS");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INIT      = 2'd1,
    RUN       = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [287:0]     s_p0;          // cipher state, bit 0 = s1
  logic [ICW-1:0]   init_cnt_p0;
  logic [W-1:0]     data_p1;
  logic             vld_p1;
  logic [W-1:0]     ks;
  logic [287:0]     s_adv;
  logic             accept;
  logic             init_done;
  logic             limit_hit;

  // One Trivium round: returns {z, next_state}.
  function automatic logic [288:0] trivium_round(input logic [287:0] st);
    logic t1, t2, t3, z;
    t1 = st[65]  ^ st[92];
    t2 = st[161] ^ st[176];
    t3 = st[242] ^ st[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (st[90]  & st[91])  ^ st[170];
    t2 = t2 ^ (st[174] & st[175]) ^ st[263];
    t3 = t3 ^ (st[285] & st[286]) ^ st[68];
    // Three shift registers: s1..s93, s94..s177, s178..s288.
    return {z, st[286:177], t2, st[175:93], t1, st[91:0], t3};
  endfunction

  // W unrolled rounds: returns {z_(W-1)..z_0, state_after_W_rounds}.
  function automatic logic [W+287:0] trivium_advance(input logic [287:0] st);
    logic [287:0] cur;
    logic [288:0] r;
    logic [W-1:0] z;
    cur = st;
    z   = '0;
    for (int i = 0; i < W; i++) begin
      r    = trivium_round(cur);
      z[i] = r[288];
      cur  = r[287:0];
    end
    return {z, cur};
  endfunction

  function automatic logic [287:0] load_state(input logic [79:0] k,
                                              input logic [79:0] v);
    return {3'b111, 112'd0, v, 13'd0, k};
  endfunction

  always_comb begin
    {ks, s_adv} = trivium_advance(s_p0);
  end

  assign accept    = s_valid && s_ready;
  assign init_done = (init_cnt_p0 == ICW'(INIT_CYC - 1));

`ifdef TRIVIUM_GEN_WORD_LIMIT_EN
  localparam int WCW = $clog2(MAX_WORDS + 1);
  logic [WCW-1:0] wcnt_p0;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      wcnt_p0 <= '0;
    end else if (accept) begin
      wcnt_p0 <= wcnt_p0 + WCW'(1);
    end
  end

  assign limit_hit = accept && (wcnt_p0 == WCW'(MAX_WORDS - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT:    if (init_done) state_d = RUN;
        RUN:     if (limit_hit) state_d = EXHAUSTED;
        default: state_d = state_q;
      endcase
    end
  end

  // ---- FSM outputs ----
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    err     = 1'b0;
    case (state_q)
      INIT: busy = 1'b1;
      // A word offered together with load is never taken.
      RUN:  s_ready = (!vld_p1 || m_ready) && !load;
`ifdef TRIVIUM_GEN_WORD_LIMIT_EN
      EXHAUSTED: err = 1'b1;
`endif
      default: ;
    endcase
  end

  assign status = state_q;

  // ---- stage p0 -> p1: state advance and output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0        <= '0;
      init_cnt_p0 <= '0;
      data_p1     <= '0;
      vld_p1      <= 1'b0;
    end else if (load) begin
      s_p0        <= load_state(key_in, iv_in);
      init_cnt_p0 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        s_p0        <= s_adv;
        init_cnt_p0 <= init_done ? '0 : init_cnt_p0 + ICW'(1);
      end
      if (accept) begin
        s_p0    <= s_adv;
        data_p1 <= s_data ^ ks;
        vld_p1  <= 1'b1;
      end else if (m_ready) begin
        // Also lets the final word drain in EXHAUSTED.
        vld_p1  <= 1'b0;
      end
    end
  end

  assign m_data  = data_p1;
  assign m_valid = vld_p1;

endmodule
